// File: rtl/udc_pkg.sv
// Shared types for the programmable up/down counter.
// Used by prog_updown_counter and udc_next_val.
package udc_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } direction_t;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        RELOAD   = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        NO_ERR   = 2'd0,
        UP_ERR   = 2'd1,
        DOWN_ERR = 2'd2,
        STEP_ERR = 2'd3
    } err_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_ERROR = 2'd3;

    // Externally visible status for each FSM state.
    function automatic status_t state_to_status(input state_t s);
        status_t st;
        case (s)
            ST_IDLE:  st = READY;
            ST_RUN:   st = BUSY;
            ST_DONE:  st = DONE;
            default:  st = ERROR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/udc_next_val.sv
// Next-count arithmetic: advances by step toward end_i, clamping to end_i
// so the unsigned count never overshoots or wraps.
module udc_next_val
    import udc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] end_i,
    input  logic [WIDTH-1:0] step_i,
    input  direction_t       dir_i,
    output logic [WIDTH-1:0] next_cnt_c,
    output logic             at_end_c,
    output logic             hit_end_c
);

    logic [WIDTH-1:0] dist_c;
    logic             past_end_c;

    always_comb begin
        dist_c     = '0;
        past_end_c = 1'b0;
        next_cnt_c = cnt_i;
        at_end_c   = (cnt_i == end_i);

        // Distance is taken before any add/subtract; a count already beyond
        // end_i is pulled straight back onto it rather than stepping further.
        if (dir_i == UP) begin
            past_end_c = (cnt_i > end_i);
            dist_c     = end_i - cnt_i;
        end else begin
            past_end_c = (cnt_i < end_i);
            dist_c     = cnt_i - end_i;
        end

        hit_end_c = past_end_c || (dist_c <= step_i);

        if (hit_end_c) begin
            next_cnt_c = end_i;
        end else if (dir_i == UP) begin
            next_cnt_c = cnt_i + step_i;
        end else begin
            next_cnt_c = cnt_i - step_i;
        end
    end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with one-shot and reload modes.
// Optional PROG_UDC_RELOAD_CNT_EN adds a saturating reload_count output.
module prog_updown_counter
    import udc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RLD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             en,
    input  direction_t       direction,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] cnt,
    output status_t          status,
    output err_t             error_status,
    output logic             done_pulse
`ifdef PROG_UDC_RELOAD_CNT_EN
   ,output logic [RLD_W-1:0] reload_count
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end
    if (RLD_W < 1) begin : g_bad_rld_w
        $error("RLD_W must be at least 1");
    end

    state_t           state_q,  state_d;
    status_t          status_q, status_d;
    err_t             err_q,    err_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] start_q,  start_d;
    logic [WIDTH-1:0] end_q,    end_d;
    logic [WIDTH-1:0] step_q,   step_d;
    direction_t       dir_q,    dir_d;
    mode_t            mode_q,   mode_d;

    logic [WIDTH-1:0] next_cnt_c;
    logic             at_end_c;
    logic             hit_end_c;
    err_t             start_err_c;

`ifdef PROG_UDC_RELOAD_CNT_EN
    logic [RLD_W-1:0] rld_q, rld_d;
`endif

    udc_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .cnt_i      (cnt_q),
        .end_i      (end_q),
        .step_i     (step_q),
        .dir_i      (dir_q),
        .next_cnt_c (next_cnt_c),
        .at_end_c   (at_end_c),
        .hit_end_c  (hit_end_c)
    );

    // Config sanity check on the raw inputs, first failing rule wins.
    always_comb begin
        start_err_c = NO_ERR;
        if ((direction == UP) && (end_val < start_val)) begin
            start_err_c = UP_ERR;
        end else if ((direction == DOWN) && (end_val > start_val)) begin
            start_err_c = DOWN_ERR;
        end else if (step == '0) begin
            start_err_c = STEP_ERR;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        start_d = start_q;
        end_d   = end_q;
        step_d  = step_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
`ifdef PROG_UDC_RELOAD_CNT_EN
        rld_d   = rld_q;
`endif

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = NO_ERR;
`ifdef PROG_UDC_RELOAD_CNT_EN
            rld_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        start_d = start_val;
                        end_d   = end_val;
                        step_d  = step;
                        dir_d   = direction;
                        mode_d  = mode;
                        err_d   = start_err_c;
`ifdef PROG_UDC_RELOAD_CNT_EN
                        rld_d   = '0;
`endif
                        if (start_err_c != NO_ERR) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = start_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (at_end_c) begin
                            done_d = 1'b1;
                            if (mode_q == ONE_SHOT) begin
                                state_d = ST_DONE;
                            end else begin
                                cnt_d = start_q;
`ifdef PROG_UDC_RELOAD_CNT_EN
                                if (!(&rld_q)) begin
                                    rld_d = rld_q + RLD_W'(1);
                                end
`endif
                            end
                        end else begin
                            cnt_d = hit_end_c ? end_q : next_cnt_c;
                        end
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        status_d = state_to_status(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            status_q <= READY;
            err_q    <= NO_ERR;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            start_q  <= '0;
            end_q    <= '0;
            step_q   <= '0;
            dir_q    <= UP;
            mode_q   <= ONE_SHOT;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            start_q  <= start_d;
            end_q    <= end_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
        end
    end

`ifdef PROG_UDC_RELOAD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rld_q <= '0;
        end else begin
            rld_q <= rld_d;
        end
    end

    assign reload_count = rld_q;
`endif

    assign cnt          = cnt_q;
    assign status       = status_q;
    assign error_status = err_q;
    assign done_pulse   = done_q;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter (WIDTH=8); honours
// PROG_UDC_RELOAD_CNT_EN when the design is built with it.
module tb_prog_updown_counter;
    import udc_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         en = 1'b0;
    direction_t   direction = UP;
    mode_t        mode = ONE_SHOT;
    logic [W-1:0] start_val = '0;
    logic [W-1:0] end_val = '0;
    logic [W-1:0] step = '0;
    logic [W-1:0] cnt;
    status_t      status;
    err_t         error_status;
    logic         done_pulse;
`ifdef PROG_UDC_RELOAD_CNT_EN
    logic [RW-1:0] reload_count;
`endif

    prog_updown_counter #(
        .WIDTH (W),
        .RLD_W (RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .start        (start),
        .en           (en),
        .direction    (direction),
        .mode         (mode),
        .start_val    (start_val),
        .end_val      (end_val),
        .step         (step),
        .cnt          (cnt),
        .status       (status),
        .error_status (error_status),
        .done_pulse   (done_pulse)
`ifdef PROG_UDC_RELOAD_CNT_EN
       ,.reload_count (reload_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int status;
        int err;
        int done;
        int rld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0 idle, 1 run, 2 done, 3 error.
    int         ms = 0, mc = 0, me = 0, mr = 0;
    int         ls = 0, le = 0, lst = 0;
    direction_t ld = UP;
    mode_t      lm = ONE_SHOT;

    int s32[5];
    int s33[9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; mc = 0; me = 0; mr = 0;
        ls = 0; le = 0; lst = 0; ld = UP; lm = ONE_SHOT;
    endtask

    task automatic model_edge(input logic c, input logic s, input logic e,
                              input direction_t d, input mode_t m,
                              input int sv, input int ev, input int stp);
        exp_t x;
        int   nd;
        nd = 0;
        if (c) begin
            ms = 0; mc = 0; me = 0; mr = 0;
        end else if ((ms == 0 || ms == 2) && s) begin
            ls = sv; le = ev; lst = stp; ld = d; lm = m; mr = 0;
            if (d == UP && ev < sv)        me = 1;
            else if (d == DOWN && ev > sv) me = 2;
            else if (stp == 0)             me = 3;
            else                           me = 0;
            if (me != 0) ms = 3;
            else begin ms = 1; mc = sv; end
        end else if (ms == 1 && e) begin
            if (mc == le) begin
                nd = 1;
                if (lm == ONE_SHOT) ms = 2;
                else begin
                    mc = ls;
                    if (mr < 65535) mr++;
                end
            end else if (ld == UP) begin
                mc = (mc + lst > le) ? le : mc + lst;
            end else begin
                mc = (mc - lst < le) ? le : mc - lst;
            end
        end
        x = '{mc, ms, me, nd, mr};
        sb.push_back(x);
    endtask

    task automatic compare_pop(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(1), 32'(0));
            return;
        end
        x = sb.pop_front();
        check({tag, ".cnt"},    32'(cnt),          32'(x.cnt));
        check({tag, ".status"}, 32'(status),       32'(x.status));
        check({tag, ".err"},    32'(error_status), 32'(x.err));
        check({tag, ".done"},   32'(done_pulse),   32'(x.done));
`ifdef PROG_UDC_RELOAD_CNT_EN
        check({tag, ".rld"},    32'(reload_count), 32'(x.rld));
`endif
    endtask

    // One clock: drive inputs, predict, let the edge happen, compare.
    task automatic cyc(input string tag, input logic c, input logic s, input logic e,
                       input direction_t d, input mode_t m,
                       input int sv, input int ev, input int stp);
        clear = c; start = s; en = e; direction = d; mode = m;
        start_val = W'(sv); end_val = W'(ev); step = W'(stp);
        model_edge(c, s, e, d, m, sv, ev, stp);
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    // Run cycle with noisy config inputs that must be ignored.
    task automatic run(input string tag, input logic e);
        cyc(tag, 1'b0, 1'b0, e, direction_t'($urandom_range(0, 1)),
            mode_t'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cnt"},    32'(cnt),          32'(0));
        check({tag, ".status"}, 32'(status),       32'(READY));
        check({tag, ".err"},    32'(error_status), 32'(NO_ERR));
        check({tag, ".done"},   32'(done_pulse),   32'(0));
`ifdef PROG_UDC_RELOAD_CNT_EN
        check({tag, ".rld"},    32'(reload_count), 32'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s32 = '{10, 13, 16, 19, 20};
        s33 = '{5, 3, 1, 0, 5, 3, 1, 0, 5};

        #3;
        check_reset_outputs("por");
        #9;
        rst_n = 1'b1;

        // Up one-shot, first start on the first edge after reset release.
        cyc("up_start", 0, 1, 1, UP, ONE_SHOT, 10, 20, 3);
        check("up_seq0", 32'(cnt), 32'(s32[0]));
        for (int i = 1; i < 5; i++) begin
            run("up_run", 1'b1);
            check($sformatf("up_seq%0d", i), 32'(cnt), 32'(s32[i]));
        end
        run("up_end", 1'b1);
        check("up_done_pulse", 32'(done_pulse), 32'(1));
        check("up_done_status", 32'(status), 32'(DONE));
        run("up_hold1", 1'b1);
        run("up_hold2", 1'b0);
        check("up_hold_cnt", 32'(cnt), 32'(20));

        // Down reload, restarted from DONE.
        cyc("dn_start", 0, 1, 1, DOWN, RELOAD, 5, 0, 2);
        check("dn_seq0", 32'(cnt), 32'(s33[0]));
        for (int i = 1; i < 9; i++) begin
            run("dn_run", 1'b1);
            check($sformatf("dn_seq%0d", i), 32'(cnt), 32'(s33[i]));
        end
        check("dn_wrap_pulse", 32'(done_pulse), 32'(1));
`ifdef PROG_UDC_RELOAD_CNT_EN
        check("dn_rld2", 32'(reload_count), 32'(2));
`endif
        cyc("dn_clear", 1, 0, 1, UP, ONE_SHOT, 0, 0, 0);

        // Error handling: only clear leaves ERROR.
        cyc("err_up", 0, 1, 1, UP, ONE_SHOT, 9, 3, 1);
        check("err_up_code", 32'(error_status), 32'(UP_ERR));
        cyc("err_ign", 0, 1, 1, UP, ONE_SHOT, 0, 5, 1);
        check("err_ign_status", 32'(status), 32'(ERROR));
        cyc("err_clr", 1, 0, 1, UP, ONE_SHOT, 0, 0, 0);
        cyc("err_step", 0, 1, 1, UP, ONE_SHOT, 1, 5, 0);
        check("err_step_code", 32'(error_status), 32'(STEP_ERR));
        cyc("err_clr2", 1, 0, 0, UP, ONE_SHOT, 0, 0, 0);
        cyc("err_dn", 0, 1, 1, DOWN, ONE_SHOT, 3, 9, 1);
        cyc("err_clr3", 1, 0, 0, UP, ONE_SHOT, 0, 0, 0);
        cyc("err_prio", 0, 1, 1, UP, ONE_SHOT, 9, 3, 0);
        check("err_prio_code", 32'(error_status), 32'(UP_ERR));
        cyc("err_clr4", 1, 0, 0, UP, ONE_SHOT, 0, 0, 0);

        // Top-of-range clamp with a pause.
        cyc("top_start", 0, 1, 1, UP, ONE_SHOT, 250, 255, 4);
        run("top_r1", 1'b1);
        check("top_254", 32'(cnt), 32'(254));
        for (int i = 0; i < 3; i++) run("top_pause", 1'b0);
        check("top_pause_cnt", 32'(cnt), 32'(254));
        check("top_pause_busy", 32'(status), 32'(BUSY));
        run("top_r2", 1'b1);
        check("top_255", 32'(cnt), 32'(255));
        run("top_end", 1'b1);

        // start_val == end_val finishes on first enabled cycle.
        cyc("eq_start", 0, 1, 0, UP, ONE_SHOT, 7, 7, 1);
        run("eq_run", 1'b1);
        check("eq_done", 32'(status), 32'(DONE));

        // clear wins over start.
        cyc("clr_start", 1, 1, 1, UP, ONE_SHOT, 3, 9, 1);
        check("clr_start_status", 32'(status), 32'(READY));

        // Asynchronous reset mid-run.
        cyc("ar_start", 0, 1, 1, UP, RELOAD, 0, 200, 1);
        run("ar_r1", 1'b1);
        run("ar_r2", 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #2;
        rst_n = 1'b1;
        cyc("ar_restart", 0, 1, 1, DOWN, ONE_SHOT, 6, 2, 3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0), direction_t'($urandom_range(0, 1)),
                mode_t'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 6))
                                            : int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_updown_counter.md
PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning counter/start/end/step width in bits.
REQ-002 SHALL have parameter RLD_W, default 16, meaning reload-counter width (used only under REQ-028).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous clear to idle.
REQ-006 start  input  1  single-cycle request to load config and begin counting.
REQ-007 en  input  1  run enable; 0 pauses the count while in RUN.
REQ-008 direction  input  direction_t  UP or DOWN; sampled at accepted start.
REQ-009 mode  input  mode_t  ONE_SHOT or RELOAD; sampled at accepted start.
REQ-010 start_val, end_val, step  input  WIDTH each  unsigned config; sampled at accepted start.
REQ-011 cnt  output  WIDTH  current count.
REQ-012 status  output  status_t  READY, BUSY, DONE, ERROR.
REQ-013 error_status  output  err_t  NO_ERR, UP_ERR, DOWN_ERR, STEP_ERR; registered.
REQ-014 done_pulse  output  1  one-cycle strobe in the cycle after cnt first equals end_val per pass.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE, ERROR; status SHALL be READY, BUSY, DONE, ERROR respectively.
REQ-016 start SHALL be accepted only in IDLE or DONE; start in RUN or ERROR SHALL be ignored.
REQ-017 On accepted start, config SHALL be latched; UP with end_val<start_val gives UP_ERR, DOWN with end_val>start_val gives DOWN_ERR, step==0 gives STEP_ERR (priority in that order), each entering ERROR next cycle with cnt unchanged.
REQ-018 Valid start SHALL set cnt=start_val and status=BUSY on the next edge (latency 1); start_val==end_val SHALL be valid and hit end on first enabled RUN cycle.
REQ-019 In RUN with en=1: if cnt==end, it SHALL be handled per REQ-021/022; else if remaining distance |end-cnt| <= step, cnt SHALL become end exactly (no overshoot); else cnt SHALL advance by step in latched direction.
REQ-020 Arithmetic SHALL be unsigned WIDTH-bit, with distance compared before add/subtract, so cnt never wraps past 0 or 2^WIDTH-1.
REQ-021 ONE_SHOT: on the enabled cycle with cnt==end, FSM SHALL go DONE, cnt SHALL hold, done_pulse SHALL assert for that one cycle.
REQ-022 RELOAD: on the enabled cycle with cnt==end, done_pulse SHALL assert, cnt SHALL reload to latched start, FSM SHALL stay RUN.
REQ-023 en=0 in RUN SHALL hold cnt and status BUSY; en SHALL be ignored outside RUN.
REQ-024 Config input changes after acceptance SHALL have no effect until the next accepted start.
REQ-025 clear SHALL override start and en: next edge gives IDLE, cnt=0, error_status=NO_ERR, done_pulse=0; it is the only exit from ERROR.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cnt=0, status=READY, error_status=NO_ERR, done_pulse=0, latched config=0, regardless of clk; mid-RUN reset SHALL discard the pass.
REQ-027 First start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro PROG_UDC_RELOAD_CNT_EN defined: SHALL add output reload_count [RLD_W-1:0], incremented per RELOAD wrap, saturating at all-ones, zeroed by reset, clear, or accepted start.
REQ-029 Macro undefined: reload_count port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package udc_pkg SHALL hold direction_t, mode_t, status_t, err_t, and FSM state typedef.
REQ-031 Sub-module udc_next_val (combinational: cnt, end, step, direction -> next cnt, at_end, hit_end) SHALL contain the REQ-019/020 arithmetic.

Verification
REQ-032 WIDTH=8, UP, ONE_SHOT, start=10, end=20, step=3, en=1 -> cnt 10,13,16,19,20; done_pulse once; status DONE; cnt holds 20.
REQ-033 DOWN, RELOAD, start=5, end=0, step=2 -> cnt 5,3,1,0,5,3...; done_pulse each pass; reload_count 1,2,... when macro defined.
REQ-034 UP start=9 end=3 -> ERROR/UP_ERR; start ignored; clear -> IDLE, cnt=0, NO_ERR. step=0 -> STEP_ERR.
REQ-035 WIDTH=8, UP, start=250, end=255, step=4 -> cnt 250,254,255, no wrap; en=0 for 3 cycles mid-run holds cnt, BUSY.
REQ-036 rst_n asserted mid-RUN between edges -> outputs at reset values immediately; start same cycle as clear -> IDLE.
